// File: rtl/bitbang_pkg.sv
// Shared constants, FSM state and quarter encodings for the bitbang transmitter.
// State ST_GAP exists only when BITBANG_TX_GAP_EN is defined.
package bitbang_pkg;

  localparam logic [15:0] ON_PATTERN  = 16'hFAB1;
  localparam logic [15:0] OFF_PATTERN = 16'hFAB0;
  localparam int          FRAME_BITS  = 32;
  localparam int          CTRL_BITS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef BITBANG_TX_GAP_EN
    ,ST_GAP  = 2'd2
`endif
  } state_t;

  // Gray order keeps s_clk equal to bit 0 of a single flop, so it cannot glitch.
  typedef enum logic [1:0] {
    QTR_0 = 2'b00,
    QTR_1 = 2'b01,
    QTR_2 = 2'b11,
    QTR_3 = 2'b10
  } qtr_t;

  function automatic qtr_t qtr_next(input qtr_t q);
    case (q)
      QTR_0:   return QTR_1;
      QTR_1:   return QTR_2;
      QTR_2:   return QTR_3;
      default: return QTR_0;
    endcase
  endfunction

  function automatic logic [CTRL_BITS-1:0] ctrl_pattern(input logic off);
    return off ? OFF_PATTERN : ON_PATTERN;
  endfunction

endpackage

// File: rtl/bitbang_tx_qtick.sv
// Quarter-period tick: one-cycle pulse every QTR_CYCLES enabled cycles, restarted by clr.
// First tick lands QTR_CYCLES cycles after the cycle clr is high.
module bitbang_tx_qtick #(
  parameter int QTR_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(QTR_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= RELOAD;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == 8'd0) ? RELOAD : cnt - 8'd1;
    end
  end

  assign tick = en && (cnt == 8'd0);

endmodule

// File: rtl/bitbang_tx.sv
// Two-wire bitbang serialiser: 32 data/control bit-periods per word, 128*QTR_CYCLES cycles per frame.
// in_ready only in IDLE; BITBANG_TX_GAP_EN adds a GAP_CYCLES quiet period after every frame.
module bitbang_tx
  import bitbang_pkg::*;
#(
  parameter int QTR_CYCLES = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_off,
  output logic        s_clk,
  output logic        s_data,
  output logic        busy,
  output logic        frame_done,
  output logic        rx_active
);

  localparam int                BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  CTRL_LIMIT = BIT_W'(CTRL_BITS);

  if (QTR_CYCLES < 2 || QTR_CYCLES > 255 || GAP_CYCLES < 1) begin : g_bad_params
    $error("bitbang_tx: QTR_CYCLES must be 2..255 and GAP_CYCLES >= 1");
  end

  state_t                 state, state_nxt;
  qtr_t                   qtr;
  logic [BIT_W-1:0]       bit_idx;
  logic [FRAME_BITS-1:0]  data_sr;
  logic                   off_r;
  logic                   accept, shifting, qtick, last_qtr, ctrl_bit;

  assign accept   = in_valid && in_ready;
  assign shifting = (state == ST_SHIFT);
  assign last_qtr = shifting && qtick && (qtr == QTR_3) && (bit_idx == '0);

  bitbang_tx_qtick #(.QTR_CYCLES(QTR_CYCLES)) u_qtick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept),
    .en     (shifting),
    .tick   (qtick)
  );

`ifdef BITBANG_TX_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_cnt <= '0;
    end else if (last_qtr) begin
      gap_cnt <= GW'(GAP_CYCLES - 1);
    end else if (state == ST_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
`ifdef BITBANG_TX_GAP_EN
      ST_SHIFT: if (last_qtr) state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
`else
      ST_SHIFT: if (last_qtr) state_nxt = ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control bits stay zero until the last 16 periods so only the final falling edge completes the pattern.
  assign ctrl_bit = (bit_idx < CTRL_LIMIT) && ctrl_pattern(off_r)[bit_idx[3:0]];

  always_comb begin
    in_ready   = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    frame_done = last_qtr;
    s_clk      = qtr[0];
    s_data     = shifting && (qtr[1] ? ctrl_bit : data_sr[FRAME_BITS-1]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qtr       <= QTR_0;
      bit_idx   <= LAST_BIT;
      data_sr   <= '0;
      off_r     <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      if (accept) begin
        qtr     <= QTR_0;
        bit_idx <= LAST_BIT;
        data_sr <= in_off ? '0 : in_data;
        off_r   <= in_off;
      end else if (shifting && qtick) begin
        qtr <= qtr_next(qtr);
        if (qtr == QTR_3) begin
          bit_idx <= bit_idx - BIT_W'(1);
          data_sr <= {data_sr[FRAME_BITS-2:0], 1'b0};
        end
      end
      if (last_qtr) rx_active <= !off_r;
    end
  end

endmodule

// File: tb/tb_bitbang_tx.sv
// Directed bench for bitbang_tx with an attached model of the fabric-side receiver.
// Checks frame timing, receiver load/strobe, back-to-back, reset abort and edge timing.
module tb_bitbang_tx;

  localparam int QTR       = 2;
  localparam int GAP       = 16;
  localparam int FRAME_CYC = 128 * QTR;
`ifdef BITBANG_TX_GAP_EN
  localparam int EXTRA = GAP;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_off = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, s_clk, s_data, busy, frame_done, rx_active;

  bitbang_tx #(.QTR_CYCLES(QTR), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_off     (in_off),
    .s_clk      (s_clk),
    .s_data     (s_data),
    .busy       (busy),
    .frame_done (frame_done),
    .rx_active  (rx_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  // Receiver model: data on rising edges, control on falling edges, strobe when control reaches FAB1.
  logic [31:0] rcv_sr = '0, rcv_data = '0;
  logic [15:0] rcv_ctrl = '0;
  logic        rcv_active = 1'b0;
  int          strobes = 0, falls = 0, ctrl_bad = 0;

  always @(posedge s_clk) rcv_sr = {rcv_sr[30:0], s_data};

  always @(negedge s_clk) begin
    rcv_ctrl = {rcv_ctrl[14:0], s_data};
    falls++;
    if ((rcv_ctrl == 16'hFAB1 || rcv_ctrl == 16'hFAB0) && falls != 32) ctrl_bad++;
    if (rcv_ctrl == 16'hFAB1) begin
      strobes++;
      rcv_data   = rcv_sr;
      rcv_active = 1'b1;
    end else if (rcv_ctrl == 16'hFAB0) begin
      rcv_active = 1'b0;
    end
  end

  always @(posedge busy) falls = 0;

  // Setup/hold monitor in clk cycles around every s_clk edge.
  int   since_clk = 1000, since_dat = 1000, edge_bad = 0;
  logic pc = 1'b0, pd = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      since_clk = 1000;
      since_dat = 1000;
    end else begin
      since_clk++;
      since_dat++;
      if (s_clk !== pc) begin
        if (since_dat < QTR) edge_bad++;
        since_clk = 0;
      end
      if (s_data !== pd) begin
        if (since_clk < QTR) edge_bad++;
        since_dat = 0;
      end
    end
    pc = s_clk;
    pd = s_data;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns the acceptance cycle index.
  task automatic start_frame(input logic [31:0] w, input logic off, output int t_acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    in_off   = off;
    while (in_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 4000), 32'd1);
    t_acc = cyc;
  endtask

  task automatic finish_frame(input int t_acc, input logic keep_valid,
                              output int k_done, output int k_rise, output int rises,
                              output logic rdy_ok, output logic back, output logic quiet);
    int   k;
    logic p;
    k_done = -1; k_rise = -1; rises = 0;
    rdy_ok = 1'b1; back = 1'b0; quiet = 1'b1;
    p = 1'b0;
    k = 0;
    while (k < FRAME_CYC + 1 + EXTRA) begin
      @(negedge clk);
      k = cyc - t_acc;
      if (k == 1) in_valid = keep_valid;
      if (k <= FRAME_CYC + EXTRA) begin
        if (in_ready !== 1'b0 || busy !== 1'b1) rdy_ok = 1'b0;
      end else begin
        back = (in_ready === 1'b1);
      end
      if (k > FRAME_CYC && (s_clk !== 1'b0 || s_data !== 1'b0)) quiet = 1'b0;
      if (s_clk === 1'b1 && p === 1'b0) begin
        rises++;
        if (k_rise < 0) k_rise = k;
      end
      p = s_clk;
      if (frame_done === 1'b1) k_done = (k_done < 0) ? k : -2;
    end
  endtask

  int          t, t1, t2, kd, kr, rises, s0, bad, on_cnt;
  logic        rdy_ok, back, quiet, last_off, off;
  logic [31:0] w, last_on;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_s_clk", 32'(s_clk), 32'd0);
    chk("rst_s_data", 32'(s_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rx_active", 32'(rx_active), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // Single ON frame
    s0 = strobes;
    start_frame(32'hDEADBEEF, 1'b0, t);
    finish_frame(t, 1'b0, kd, kr, rises, rdy_ok, back, quiet);
    chk("on_rises", rises, 32);
    chk("on_first_rise", kr, 1 + QTR);
    chk("on_frame_done", kd, FRAME_CYC);
    chk("on_ready_low", 32'(rdy_ok), 32'd1);
    chk("on_ready_back", 32'(back), 32'd1);
    chk("on_quiet_after", 32'(quiet), 32'd1);
    chk("on_strobes", strobes - s0, 1);
    chk("on_rcv_data", rcv_data, 32'hDEADBEEF);
    chk("on_rcv_active", 32'(rcv_active), 32'd1);
    chk("on_rx_active", 32'(rx_active), 32'd1);

    // ON then OFF
    s0 = strobes;
    start_frame(32'h12345678, 1'b0, t);
    finish_frame(t, 1'b0, kd, kr, rises, rdy_ok, back, quiet);
    chk("on2_rcv_data", rcv_data, 32'h12345678);
    start_frame(32'h89ABCDEF, 1'b1, t);
    finish_frame(t, 1'b0, kd, kr, rises, rdy_ok, back, quiet);
    chk("off_rises", rises, 32);
    chk("off_frame_done", kd, FRAME_CYC);
    chk("off_strobes", strobes - s0, 1);
    chk("off_rcv_data", rcv_data, 32'h12345678);
    chk("off_rcv_active", 32'(rcv_active), 32'd0);
    chk("off_rx_active", 32'(rx_active), 32'd0);

    // Back-to-back with in_valid held
    s0 = strobes;
    start_frame(32'h00000001, 1'b0, t1);
    finish_frame(t1, 1'b1, kd, kr, rises, rdy_ok, back, quiet);
    chk("b2b_first_data", rcv_data, 32'h00000001);
    chk("b2b_first_ready_low", 32'(rdy_ok), 32'd1);
    start_frame(32'hFFFFFFFF, 1'b0, t2);
    chk("b2b_spacing", t2 - t1, FRAME_CYC + 1 + EXTRA);
    finish_frame(t2, 1'b0, kd, kr, rises, rdy_ok, back, quiet);
    chk("b2b_second_data", rcv_data, 32'hFFFFFFFF);
    chk("b2b_second_ready_low", 32'(rdy_ok), 32'd1);
    chk("b2b_strobes", strobes - s0, 2);

    // Reset in the middle of bit 10
    s0 = strobes;
    start_frame(32'hA5A5A5A5, 1'b0, t);
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc - t < 2 + 21 * 4 * QTR) @(negedge clk);
    chk("abort_bit10_data", 32'(s_data), 32'd1);
    chk("abort_bit10_clk", 32'(s_clk), 32'd0);
    resetn = 1'b0;
    #1;
    chk("abort_s_clk", 32'(s_clk), 32'd0);
    chk("abort_s_data", 32'(s_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_rx_active", 32'(rx_active), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_hold_lines", 32'({s_clk, s_data}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_no_strobe", strobes - s0, 0);
    start_frame(32'hCAFEF00D, 1'b0, t);
    finish_frame(t, 1'b0, kd, kr, rises, rdy_ok, back, quiet);
    chk("recover_strobes", strobes - s0, 1);
    chk("recover_rcv_data", rcv_data, 32'hCAFEF00D);
    chk("recover_rx_active", 32'(rx_active), 32'd1);

    // Random stream, in_valid held throughout
    s0 = strobes; bad = 0; on_cnt = 0;
    last_on = 32'hCAFEF00D; last_off = 1'b0;
    for (int i = 0; i < 100; i++) begin
      w   = $urandom;
      off = ($urandom_range(0, 3) == 0);
      start_frame(w, off, t);
      finish_frame(t, (i != 99), kd, kr, rises, rdy_ok, back, quiet);
      if (kd != FRAME_CYC || rises != 32 || !rdy_ok || !back || !quiet) bad++;
      if (!off) begin
        on_cnt++;
        last_on = w;
      end
      last_off = off;
    end
    chk("rand_frame_shape", bad, 0);
    chk("rand_strobes", strobes - s0, on_cnt);
    chk("rand_rcv_data", rcv_data, last_on);
    chk("rand_rcv_active", 32'(rcv_active), 32'(!last_off));
    chk("rand_rx_active", 32'(rx_active), 32'(!last_off));
    chk("edge_setup_hold", edge_bad, 0);
    chk("ctrl_early_pattern", ctrl_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
